nf10_axis_pktgen: RTL and testbench

- Parametrised AXI4-Stream master packet generator; successor to the fixed-format bench signal generator.
- Adds configurable bus width, configurable packet length (fixed or incrementing), inter-packet gap, packet-count limit, rotating destination port, and deterministic payload.
- Drives a single output-queue input in simulation and hardware self-test, using the NetFPGA tuser format.

---
 rtl/nf10_pktgen_pkg.sv | 41 ++++
 rtl/nf10_pktgen_beat.sv | 34 +++
 rtl/nf10_axis_pktgen.sv | 187 ++++++++++++++++++
 tb/tb_nf10_axis_pktgen.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_pktgen_pkg.sv
// Shared types and helpers for the nf10 AXI4-Stream packet generator.
package nf10_pktgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit offsets of the NetFPGA metadata fields inside tuser
    localparam int LEN_LO = 0;
    localparam int SRC_LO = 16;
    localparam int DST_LO = 24;

    // Widest strobe vector the helper can describe (1024-bit bus)
    localparam int MAX_BYTES = 128;

    // Strobe for the final beat: low (len mod bytes) bits set, or all bytes when the remainder is zero
    function automatic logic [MAX_BYTES-1:0] strb_for_len(input logic [15:0] len, input int bytes);
        logic [MAX_BYTES-1:0] ones;
        int rem;
        ones = '1;
        rem  = int'(len) % bytes;
        if (rem == 0)
            strb_for_len = ones >> (MAX_BYTES - bytes);
        else
            strb_for_len = ones >> (MAX_BYTES - rem);
    endfunction

    // Force a requested length into the legal window
    function automatic logic [15:0] clamp_len(input logic [15:0] len, input int min_len, input int max_len);
        if (int'(len) < min_len)
            clamp_len = 16'(min_len);
        else if (int'(len) > max_len)
            clamp_len = 16'(max_len);
        else
            clamp_len = len;
    endfunction

endpackage

// File: rtl/nf10_pktgen_beat.sv
// Per-beat payload, strobe and tlast for the packet generator, derived from sequence, beat index and length.
module nf10_pktgen_beat
    import nf10_pktgen_pkg::*;
#(
    parameter int DATA_WIDTH = 256
) (
    input  logic [15:0]             seq_lo,
    input  logic [15:0]             beat,
    input  logic [15:0]             len,
    output logic [DATA_WIDTH-1:0]   data,
    output logic [DATA_WIDTH/8-1:0] strb,
    output logic                    last
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LANES = DATA_WIDTH / 32;

    logic [16:0] num_beats;

    // Lane k of beat b carries {seq, b*LANES+k}; the final beat gets the partial strobe
    always_comb begin
        num_beats = 17'((32'(len) + 32'(BYTES) - 32'd1) / 32'(BYTES));
        last      = ({1'b0, beat} == (num_beats - 17'd1));
        data      = '0;
        for (int k = 0; k < LANES; k++) begin
            data[32*k +: 32] = {seq_lo, 16'(32'(beat) * 32'(LANES) + 32'(k))};
        end
        if (last)
            strb = BYTES'(strb_for_len(len, BYTES));
        else
            strb = '1;
    end

endmodule

// File: rtl/nf10_axis_pktgen.sv
// Parametrised AXI4-Stream packet generator with NetFPGA tuser metadata.
// Optional statistics counters (stat_bytes, stat_stall) are built when PKTGEN_STATS_EN is defined.
module nf10_axis_pktgen
    import nf10_pktgen_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int MIN_LEN              = 60,
    parameter int MAX_LEN              = 1518,
    parameter int NUM_PORTS            = 4,
    parameter int SRC_PORT             = 0
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              cfg_enable,
    input  logic                              cfg_mode,
    input  logic [15:0]                       cfg_len,
    input  logic [7:0]                        cfg_gap,
    input  logic [31:0]                       cfg_pkt_limit,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tlast,
    output logic [31:0]                       pkt_sent,
`ifdef PKTGEN_STATS_EN
    output logic [63:0]                       stat_bytes,
    output logic [31:0]                       stat_stall,
`endif
    output logic                              done
);

    localparam logic [7:0] SRC_ONEHOT = 8'(1 << (2 * SRC_PORT));

    state_t                            state;
    logic [31:0]                       seq;
    logic [15:0]                       len_q;
    logic                              mode_q;
    logic [15:0]                       beat_idx;
    logic [7:0]                        gap_cnt;
    logic [15:0]                       inc_len;
    logic                              tvalid_q;

    logic [C_M_AXIS_DATA_WIDTH-1:0]    beat_data;
    logic [C_M_AXIS_DATA_WIDTH/8-1:0]  beat_strb;
    logic                              beat_last;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_w;
    logic [15:0]                       inc_after;
    logic [15:0]                       start_len;
    logic [1:0]                        dst_idx;
    logic                              xfer;
    logic                              limit_hit;

    nf10_pktgen_beat #(
        .DATA_WIDTH (C_M_AXIS_DATA_WIDTH)
    ) u_beat (
        .seq_lo (seq[15:0]),
        .beat   (beat_idx),
        .len    (len_q),
        .data   (beat_data),
        .strb   (beat_strb),
        .last   (beat_last)
    );

    // Length selection for the next packet and the handshake / limit conditions
    always_comb begin
        xfer      = tvalid_q && m_axis_tready;
        limit_hit = (cfg_pkt_limit != 32'd0) && ((pkt_sent + 32'd1) == cfg_pkt_limit);
        if (mode_q)
            inc_after = (inc_len >= 16'(MAX_LEN)) ? 16'(MIN_LEN) : inc_len + 16'd1;
        else
            inc_after = inc_len;
        if (cfg_mode)
            start_len = (state == SEND) ? inc_after : inc_len;
        else
            start_len = clamp_len(cfg_len, MIN_LEN, MAX_LEN);
        dst_idx = 2'(seq % 32'(NUM_PORTS));
        tuser_w = '0;
        tuser_w[LEN_LO +: 16] = len_q;
        tuser_w[SRC_LO +: 8]  = SRC_ONEHOT;
        tuser_w[DST_LO +: 8]  = 8'd1 << {dst_idx, 1'b0};
    end

    // Outputs are held at zero whenever no beat is being offered
    always_comb begin
        m_axis_tvalid = tvalid_q;
        m_axis_tdata  = tvalid_q ? beat_data : '0;
        m_axis_tstrb  = tvalid_q ? beat_strb : '0;
        m_axis_tuser  = tvalid_q ? tuser_w : '0;
        m_axis_tlast  = tvalid_q && beat_last;
    end

    // Packet sequencing FSM: idle, stream beats, inter-packet gap, limit reached
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            seq      <= '0;
            len_q    <= '0;
            mode_q   <= 1'b0;
            beat_idx <= '0;
            gap_cnt  <= '0;
            inc_len  <= 16'(MIN_LEN);
            tvalid_q <= 1'b0;
            pkt_sent <= '0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_enable) begin
                        state    <= SEND;
                        len_q    <= start_len;
                        mode_q   <= cfg_mode;
                        beat_idx <= '0;
                        tvalid_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (!beat_last) begin
                            beat_idx <= beat_idx + 16'd1;
                        end else begin
                            pkt_sent <= pkt_sent + 32'd1;
                            seq      <= seq + 32'd1;
                            inc_len  <= inc_after;
                            if (limit_hit) begin
                                state    <= DONE;
                                tvalid_q <= 1'b0;
                                done     <= 1'b1;
                            end else if (cfg_gap != 8'd0) begin
                                state    <= GAP;
                                gap_cnt  <= cfg_gap;
                                tvalid_q <= 1'b0;
                            end else if (cfg_enable) begin
                                len_q    <= start_len;
                                mode_q   <= cfg_mode;
                                beat_idx <= '0;
                            end else begin
                                state    <= IDLE;
                                tvalid_q <= 1'b0;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == 8'd1) begin
                        if (cfg_enable) begin
                            state    <= SEND;
                            len_q    <= start_len;
                            mode_q   <= cfg_mode;
                            beat_idx <= '0;
                            tvalid_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                DONE: begin
                    if (!cfg_enable) begin
                        done     <= 1'b0;
                        pkt_sent <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PKTGEN_STATS_EN
    // Cumulative completed bytes and stalled-beat cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_bytes <= '0;
            stat_stall <= '0;
        end else begin
            if (xfer && beat_last)
                stat_bytes <= stat_bytes + 64'(len_q);
            if (tvalid_q && !m_axis_tready)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nf10_axis_pktgen.sv
// Directed self-checking bench for nf10_axis_pktgen (256-bit bus); a second instance with MAX_LEN = 62
// exercises the incrementing-length wrap.
`timescale 1ns/1ps
module tb_nf10_axis_pktgen;

    localparam int DW    = 256;
    localparam int UW    = 128;
    localparam int BW    = DW / 8;
    localparam int LANES = DW / 32;

    logic clk = 1'b0;
    logic resetn;
    logic cfg_enable;
    logic inc_enable;
    logic cfg_mode;
    logic [15:0] cfg_len;
    logic [7:0]  cfg_gap;
    logic [31:0] cfg_pkt_limit;
    logic tready;

    logic          tvalid, tlast, done;
    logic [DW-1:0] tdata;
    logic [BW-1:0] tstrb;
    logic [UW-1:0] tuser;
    logic [31:0]   pkt_sent;

    logic          inc_tvalid, inc_tlast, inc_done;
    logic [DW-1:0] inc_tdata;
    logic [BW-1:0] inc_tstrb;
    logic [UW-1:0] inc_tuser;
    logic [31:0]   inc_pkt_sent;

`ifdef PKTGEN_STATS_EN
    logic [63:0] stat_bytes, inc_stat_bytes;
    logic [31:0] stat_stall, inc_stat_stall;
`endif

    int checks = 0;
    int passed = 0;
    logic [31:0] seq_model = 0;
    longint bytes_model = 0;
    int stall_model = 0;

    always #5 clk = ~clk;

    nf10_axis_pktgen u_dut (
        .clk           (clk),
        .resetn        (resetn),
        .cfg_enable    (cfg_enable),
        .cfg_mode      (cfg_mode),
        .cfg_len       (cfg_len),
        .cfg_gap       (cfg_gap),
        .cfg_pkt_limit (cfg_pkt_limit),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tstrb  (tstrb),
        .m_axis_tuser  (tuser),
        .m_axis_tlast  (tlast),
        .pkt_sent      (pkt_sent),
`ifdef PKTGEN_STATS_EN
        .stat_bytes    (stat_bytes),
        .stat_stall    (stat_stall),
`endif
        .done          (done)
    );

    nf10_axis_pktgen #(.MIN_LEN(60), .MAX_LEN(62)) u_inc (
        .clk           (clk),
        .resetn        (resetn),
        .cfg_enable    (inc_enable),
        .cfg_mode      (cfg_mode),
        .cfg_len       (cfg_len),
        .cfg_gap       (cfg_gap),
        .cfg_pkt_limit (cfg_pkt_limit),
        .m_axis_tvalid (inc_tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (inc_tdata),
        .m_axis_tstrb  (inc_tstrb),
        .m_axis_tuser  (inc_tuser),
        .m_axis_tlast  (inc_tlast),
        .pkt_sent      (inc_pkt_sent),
`ifdef PKTGEN_STATS_EN
        .stat_bytes    (inc_stat_bytes),
        .stat_stall    (inc_stat_stall),
`endif
        .done          (inc_done)
    );

    // Expected payload for one beat: lane k = {seq[15:0], b*LANES + k}
    function automatic logic [DW-1:0] exp_data(input logic [31:0] s, input int b);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < LANES; k++) r[32*k +: 32] = {s[15:0], 16'(b * LANES + k)};
        return r;
    endfunction

    task automatic test_reset();
        resetn = 1'b0; cfg_enable = 1'b0; inc_enable = 1'b0; cfg_mode = 1'b0;
        cfg_len = 16'd64; cfg_gap = 8'd0; cfg_pkt_limit = 32'd0; tready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tvalid !== 1'b0) $display("[TB] FAIL reset_tvalid: got %b expected 0", tvalid); else passed++;
        checks++; if ({tdata, tstrb, tuser, tlast} !== '0) $display("[TB] FAIL reset_outputs: got nonzero data/strb/user/last expected 0"); else passed++;
        checks++; if (pkt_sent !== 32'd0) $display("[TB] FAIL reset_pkt_sent: got %0d expected 0", pkt_sent); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fixed64();
        int beats;
        int cyc;
        int b;
        logic [31:0] s;
        beats = 0; cyc = 0;
        cfg_mode = 1'b0; cfg_len = 16'd64; cfg_gap = 8'd0; cfg_pkt_limit = 32'd3; tready = 1'b1;
        cfg_enable = 1'b1;
        while (beats < 6 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (tvalid) begin
                s = seq_model + 32'(beats / 2); b = beats % 2;
                checks++; if (tlast !== (b == 1)) $display("[TB] FAIL f64_tlast beat %0d: got %b expected %b", beats, tlast, (b == 1)); else passed++;
                checks++; if (tstrb !== 32'hFFFFFFFF) $display("[TB] FAIL f64_tstrb beat %0d: got %h expected ffffffff", beats, tstrb); else passed++;
                checks++; if (tdata !== exp_data(s, b)) $display("[TB] FAIL f64_tdata beat %0d: got %h expected %h", beats, tdata, exp_data(s, b)); else passed++;
                beats++;
            end
        end
        checks++; if (beats !== 6) $display("[TB] FAIL f64_beats: got %0d expected 6", beats); else passed++;
        checks++; if (cyc !== 6) $display("[TB] FAIL f64_back_to_back_cycles: got %0d expected 6", cyc); else passed++;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("[TB] FAIL f64_done: got %b expected 1", done); else passed++;
        checks++; if (pkt_sent !== 32'd3) $display("[TB] FAIL f64_pkt_sent: got %0d expected 3", pkt_sent); else passed++;
        checks++; if (tvalid !== 1'b0) $display("[TB] FAIL f64_tvalid_done: got %b expected 0", tvalid); else passed++;
        seq_model = seq_model + 32'd3; bytes_model += 192;
        cfg_enable = 1'b0;
        @(negedge clk);
        checks++; if ({done, pkt_sent} !== 33'd0) $display("[TB] FAIL f64_clear: got done=%b pkt_sent=%0d expected 0/0", done, pkt_sent); else passed++;
    endtask

    task automatic test_fixed_len(input logic [15:0] len_cfg, input logic [15:0] exp_len,
                                  input int exp_beats, input logic [31:0] exp_last_strb);
        int beats;
        int cyc;
        logic [7:0] exp_dst;
        logic [31:0] exp_strb;
        beats = 0; cyc = 0;
        exp_dst = 8'(1 << (2 * (seq_model % 4)));
        cfg_mode = 1'b0; cfg_len = len_cfg; cfg_gap = 8'd0; cfg_pkt_limit = 32'd1; tready = 1'b1;
        cfg_enable = 1'b1;
        while (beats < exp_beats && cyc < exp_beats + 10) begin
            @(negedge clk); cyc++;
            if (tvalid) begin
                exp_strb = (beats == exp_beats - 1) ? exp_last_strb : 32'hFFFFFFFF;
                checks++; if (tuser[31:0] !== {exp_dst, 8'h01, exp_len}) $display("[TB] FAIL len%0d_tuser beat %0d: got %h expected %h", len_cfg, beats, tuser[31:0], {exp_dst, 8'h01, exp_len}); else passed++;
                checks++; if (tstrb !== exp_strb) $display("[TB] FAIL len%0d_tstrb beat %0d: got %h expected %h", len_cfg, beats, tstrb, exp_strb); else passed++;
                checks++; if (tlast !== (beats == exp_beats - 1)) $display("[TB] FAIL len%0d_tlast beat %0d: got %b", len_cfg, beats, tlast); else passed++;
                beats++;
            end
        end
        checks++; if (beats !== exp_beats) $display("[TB] FAIL len%0d_beats: got %0d expected %0d", len_cfg, beats, exp_beats); else passed++;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("[TB] FAIL len%0d_done: got %b expected 1", len_cfg, done); else passed++;
        seq_model = seq_model + 32'd1; bytes_model += longint'(exp_len);
        cfg_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_incrementing();
        logic [15:0] lens [5];
        logic [7:0]  dsts [5];
        logic [31:0] strbs [5];
        int p;
        lens  = '{16'd60, 16'd61, 16'd62, 16'd60, 16'd61};
        dsts  = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h01};
        strbs = '{32'h0FFFFFFF, 32'h1FFFFFFF, 32'h3FFFFFFF, 32'h0FFFFFFF, 32'h1FFFFFFF};
        p = 0;
        cfg_mode = 1'b1; cfg_gap = 8'd0; cfg_pkt_limit = 32'd5; tready = 1'b1;
        inc_enable = 1'b1;
        for (int c = 0; c < 40 && p < 5; c++) begin
            @(negedge clk);
            if (inc_tvalid && inc_tlast) begin
                checks++; if (inc_tuser[15:0] !== lens[p]) $display("[TB] FAIL inc_len pkt %0d: got %0d expected %0d", p, inc_tuser[15:0], lens[p]); else passed++;
                checks++; if (inc_tuser[31:24] !== dsts[p]) $display("[TB] FAIL inc_dst pkt %0d: got %h expected %h", p, inc_tuser[31:24], dsts[p]); else passed++;
                checks++; if (inc_tstrb !== strbs[p]) $display("[TB] FAIL inc_strb pkt %0d: got %h expected %h", p, inc_tstrb, strbs[p]); else passed++;
                p++;
            end
        end
        checks++; if (p !== 5) $display("[TB] FAIL inc_packets: got %0d expected 5", p); else passed++;
        @(negedge clk);
        checks++; if ({inc_done, inc_pkt_sent} !== {1'b1, 32'd5}) $display("[TB] FAIL inc_done: got done=%b sent=%0d expected 1/5", inc_done, inc_pkt_sent); else passed++;
        inc_enable = 1'b0; cfg_mode = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        int beats;
        int cyc;
        logic stalled;
        logic [DW+BW+UW+1:0] held;
        logic [DW-1:0] ed;
        beats = 0; cyc = 0; stalled = 1'b0; held = '0;
        cfg_mode = 1'b0; cfg_len = 16'd200; cfg_gap = 8'd0; cfg_pkt_limit = 32'd2;
        tready = 1'b0; cfg_enable = 1'b1;
        while (beats < 14 && cyc < 400) begin
            @(negedge clk); cyc++;
            if (stalled) begin
                checks++; if ({tvalid, tlast, tdata, tstrb, tuser} !== held) $display("[TB] FAIL stall_stable beat %0d: outputs changed during stall", beats); else passed++;
            end
            tready = ($urandom_range(0, 9) < 3);
            stalled = tvalid && !tready;
            if (stalled) begin
                held = {tvalid, tlast, tdata, tstrb, tuser};
                stall_model++;
            end else if (tvalid) begin
                ed = exp_data(seq_model + 32'(beats / 7), beats % 7);
                checks++; if (tdata !== ed) $display("[TB] FAIL stall_tdata beat %0d: got %h expected %h", beats, tdata, ed); else passed++;
                beats++;
            end
        end
        checks++; if (beats !== 14) $display("[TB] FAIL stall_beats: got %0d expected 14", beats); else passed++;
        tready = 1'b1;
        @(negedge clk);
        checks++; if ({done, pkt_sent} !== {1'b1, 32'd2}) $display("[TB] FAIL stall_done: got done=%b sent=%0d expected 1/2", done, pkt_sent); else passed++;
        seq_model = seq_model + 32'd2; bytes_model += 400;
`ifdef PKTGEN_STATS_EN
        checks++; if (stat_stall !== 32'(stall_model)) $display("[TB] FAIL stat_stall: got %0d expected %0d", stat_stall, stall_model); else passed++;
        checks++; if (stat_bytes !== 64'(bytes_model)) $display("[TB] FAIL stat_bytes: got %0d expected %0d", stat_bytes, bytes_model); else passed++;
`endif
        cfg_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_gap();
        int phase;
        int gapc;
        phase = 0; gapc = 0;
        cfg_mode = 1'b0; cfg_len = 16'd64; cfg_gap = 8'd5; cfg_pkt_limit = 32'd2; tready = 1'b1;
        cfg_enable = 1'b1;
        for (int c = 0; c < 40 && phase < 3; c++) begin
            @(negedge clk);
            if (phase == 0) begin
                if (tvalid && tlast) phase = 1;
            end else if (phase == 1) begin
                if (!tvalid) gapc++;
                else begin
                    checks++; if (gapc !== 5) $display("[TB] FAIL gap_cycles: got %0d expected 5", gapc); else passed++;
                    checks++; if (tdata !== exp_data(seq_model + 32'd1, 0)) $display("[TB] FAIL gap_first_beat: got %h expected %h", tdata, exp_data(seq_model + 32'd1, 0)); else passed++;
                    phase = 2;
                end
            end else if (tvalid && tlast) begin
                phase = 3;
            end
        end
        checks++; if (phase !== 3) $display("[TB] FAIL gap_progress: got phase %0d expected 3", phase); else passed++;
        @(negedge clk);
        checks++; if (done !== 1'b1) $display("[TB] FAIL gap_done: got %b expected 1", done); else passed++;
        seq_model = seq_model + 32'd2; bytes_model += 128;
        cfg_enable = 1'b0; cfg_gap = 8'd0;
        @(negedge clk);
    endtask

    task automatic test_enable_drop();
        int beats;
        logic seen_last;
        beats = 0; seen_last = 1'b0;
        cfg_mode = 1'b0; cfg_len = 16'd768; cfg_gap = 8'd0; cfg_pkt_limit = 32'd0; tready = 1'b1;
        cfg_enable = 1'b1;
        for (int c = 0; c < 60 && !seen_last; c++) begin
            @(negedge clk);
            if (tvalid) begin
                if (beats == 2) cfg_enable = 1'b0;
                if (tlast) seen_last = 1'b1;
                beats++;
            end
        end
        checks++; if (beats !== 24) $display("[TB] FAIL drop_beats: got %0d expected 24", beats); else passed++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (tvalid !== 1'b0) $display("[TB] FAIL drop_idle cycle %0d: got tvalid %b expected 0", c, tvalid); else passed++;
        end
        checks++; if (pkt_sent !== 32'd1) $display("[TB] FAIL drop_pkt_sent: got %0d expected 1", pkt_sent); else passed++;
        seq_model = seq_model + 32'd1; bytes_model += 768;
    endtask

    task automatic test_reset_mid_packet();
        int beats;
        logic got;
        beats = 0; got = 1'b0;
        cfg_mode = 1'b0; cfg_len = 16'd768; cfg_pkt_limit = 32'd0; tready = 1'b1;
        cfg_enable = 1'b1;
        for (int c = 0; c < 20 && beats < 3; c++) begin
            @(negedge clk);
            if (tvalid) beats++;
        end
        #1 resetn = 1'b0;
        #1;
        checks++; if ({tvalid, tlast} !== 2'b00) $display("[TB] FAIL rst_mid_ctrl: got tvalid=%b tlast=%b expected 0/0", tvalid, tlast); else passed++;
        checks++; if ({tdata, tstrb, tuser} !== '0) $display("[TB] FAIL rst_mid_data: got nonzero payload expected 0"); else passed++;
        checks++; if (pkt_sent !== 32'd0) $display("[TB] FAIL rst_mid_pkt_sent: got %0d expected 0", pkt_sent); else passed++;
        cfg_enable = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        seq_model = 32'd0;
        cfg_len = 16'd64; cfg_pkt_limit = 32'd1; cfg_enable = 1'b1;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (tvalid) got = 1'b1;
        end
        checks++; if (tdata !== exp_data(32'd0, 0)) $display("[TB] FAIL rst_seq_restart: got %h expected %h", tdata, exp_data(32'd0, 0)); else passed++;
        checks++; if (tuser[31:24] !== 8'h01) $display("[TB] FAIL rst_dst_restart: got %h expected 01", tuser[31:24]); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1) $display("[TB] FAIL rst_after_done: got %b expected 1", done); else passed++;
        cfg_enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fixed64();
        test_fixed_len(16'd65, 16'd65, 3, 32'h00000001);
        test_fixed_len(16'd10, 16'd60, 2, 32'h0FFFFFFF);
        test_fixed_len(16'd2000, 16'd1518, 48, 32'h00003FFF);
        test_incrementing();
        test_stall();
        test_gap();
        test_enable_drop();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
